// File: rtl/instr_fetch.sv
// Instruction fetch/prefetch stage: walks a PC range, reads a 1-cycle
// synchronous instruction memory and buffers words for the datapath.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [17:0]       imem_rdata,
  output logic [17:0]       instruct,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [17:0]       word;
  } entry_t;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] endAddr;
  logic [ADDR_W-1:0] inflightAddr;
  logic              inflight;
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic              rdEn;
  logic              capture;
  logic              pop;
  entry_t            mem [DEPTH];

  // Reserve a slot for every outstanding read so capture never overflows
  assign occ = {1'b0, count} + {{CW{1'b0}}, inflight};

  always_comb begin
    rdEn    = (state == FETCH) && !load && (occ < (CW+1)'(DEPTH));
    capture = inflight && !load;
    pop     = instr_valid && instr_ready && !load;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (load) stateNext = FETCH;
      end
      FETCH: begin
        if (load) stateNext = FETCH;
        else if (rdEn && pc == endAddr) stateNext = DRAIN;
      end
      DRAIN: begin
        if (load) stateNext = FETCH;
        else if (!inflight && count == '0) stateNext = DONE;
      end
      DONE: begin
        if (load) stateNext = FETCH;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      pc           <= '0;
      endAddr      <= '0;
      inflight     <= 1'b0;
      inflightAddr <= '0;
      wrPtr        <= '0;
      rdPtr        <= '0;
      count        <= '0;
    end else begin
      state    <= stateNext;
      inflight <= rdEn;
      if (rdEn) inflightAddr <= pc;
      if (load) begin
        pc      <= start_addr;
        endAddr <= end_addr;
        wrPtr   <= '0;
        rdPtr   <= '0;
        count   <= '0;
      end else begin
        if (rdEn)    pc    <= pc + 1'b1;
        if (capture) wrPtr <= wrPtr + 1'b1;
        if (pop)     rdPtr <= rdPtr + 1'b1;
        unique case ({capture, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (capture) mem[wrPtr] <= '{pc: inflightAddr, word: imem_rdata};
  end

  always_comb begin
    instr_valid = (count != '0);
    instruct    = instr_valid ? mem[rdPtr].word : '0;
    instr_pc    = instr_valid ? mem[rdPtr].pc : '0;
    imem_rd     = rdEn;
    imem_addr   = rdEn ? pc : '0;
    busy        = (state == FETCH) || (state == DRAIN);
    done        = (state == DONE);
  end

  captureNotFull: assert property (
    @(posedge clock) disable iff (!resetn)
    !(capture && count == CW'(DEPTH))
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model returns {addr,10'h0}
// and every read and transfer is matched against queued expectations.
module tb_instr_fetch;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          load = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          imem_rd;
  logic [AW-1:0] imem_addr;
  logic [17:0]   imem_rdata = '0;
  logic [17:0]   instruct;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          busy;
  logic          done;

  instr_fetch #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .load       (load),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instruct   (instruct),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int rdCount, xferCount;
  int firstRd, lastRd, firstValid, firstXfer, lastXfer;

  logic [AW+17:0] sbQ [$];
  logic [AW-1:0]  rdQ [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) begin
    cyc        <= cyc + 1;
    imem_rdata <= imem_rd ? {imem_addr, 10'h0} : 18'h0;
  end

  always @(negedge clock) begin
    if (resetn) begin
      if (imem_rd) begin
        rdCount++;
        if (firstRd < 0) firstRd = cyc;
        lastRd = cyc;
        if (rdQ.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_addr", 32'(imem_addr), 32'(rdQ.pop_front()));
      end
      if (instr_valid && firstValid < 0) firstValid = cyc;
      if (instr_valid && instr_ready && !load) begin
        xferCount++;
        if (firstXfer < 0) firstXfer = cyc;
        lastXfer = cyc;
        if (sbQ.size() == 0) check("xfer_unexpected", 1, 0);
        else check("xfer_word", 32'({instr_pc, instruct}),
                   32'(sbQ.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic startRun(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [AW-1:0] a;
    rdQ.delete();
    sbQ.delete();
    a = s;
    for (int i = 0; i < (1 << AW); i++) begin
      rdQ.push_back(a);
      sbQ.push_back({a, a, 10'h0});
      if (a == e) break;
      a = a + 1'b1;
    end
    rdCount    = 0;
    xferCount  = 0;
    firstRd    = -1;
    lastRd     = -1;
    firstValid = -1;
    firstXfer  = -1;
    lastXfer   = -1;
    load       = 1'b1;
    start_addr = s;
    end_addr   = e;
    tick(1);
    load = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(done), 1);
  endtask

  initial begin
    #2;
    check("rst_rd", 32'(imem_rd), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", 32'(instruct), 0);
    check("rst_pc", 32'(instr_pc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    #1 resetn = 1'b1;
    tick(2);
    check("idle_busy", 32'(busy), 0);

    // basic run
    instr_ready = 1'b1;
    startRun(8'h10, 8'h13);
    waitDone(40, "t1_done");
    check("t1_reads", rdCount, 4);
    check("t1_rd_consec", lastRd - firstRd, 3);
    check("t1_latency", firstValid - firstRd, 2);
    check("t1_xfers", xferCount, 4);
    check("t1_b2b", lastXfer - firstXfer, 3);
    check("t1_sb_empty", sbQ.size(), 0);
    check("t1_busy", 32'(busy), 0);

    // single word
    startRun(8'h05, 8'h05);
    waitDone(20, "t2_done");
    check("t2_reads", rdCount, 1);
    check("t2_xfers", xferCount, 1);
    check("t2_sb_empty", sbQ.size(), 0);

    // backpressure
    instr_ready = 1'b0;
    startRun(8'h00, 8'h0F);
    tick(10);
    check("t3_reads", rdCount, DEPTH);
    check("t3_rd_idle", 32'(imem_rd), 0);
    check("t3_valid", 32'(instr_valid), 1);
    check("t3_head", 32'({instr_pc, instruct}), 32'({8'h00, 18'h0}));
    tick(3);
    check("t3_hold", 32'({instr_pc, instruct}), 32'({8'h00, 18'h0}));
    instr_ready = 1'b1;
    waitDone(100, "t3_done");
    check("t3_reads_all", rdCount, 16);
    check("t3_xfers", xferCount, 16);
    check("t3_sb_empty", sbQ.size(), 0);

    // flush with 3 buffered entries and one read in flight
    instr_ready = 1'b0;
    startRun(8'h00, 8'h0F);
    for (int i = 0; i < 20 && rdCount < 4; i++) tick(1);
    check("t4_prefill", rdCount, 4);
    startRun(8'h40, 8'h41);
    instr_ready = 1'b1;
    waitDone(40, "t4_done");
    check("t4_reads", rdCount, 2);
    check("t4_xfers", xferCount, 2);
    check("t4_sb_empty", sbQ.size(), 0);

    // address wrap
    startRun(8'hFE, 8'h01);
    waitDone(40, "t5_done");
    check("t5_xfers", xferCount, 4);
    check("t5_sb_empty", sbQ.size(), 0);

    // asynchronous reset mid-fetch
    startRun(8'h00, 8'h0F);
    tick(3);
    check("t6_busy_pre", 32'(busy), 1);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_rd", 32'(imem_rd), 0);
    check("t6_rst_addr", 32'(imem_addr), 0);
    check("t6_rst_valid", 32'(instr_valid), 0);
    check("t6_rst_instr", 32'(instruct), 0);
    check("t6_rst_busy", 32'(busy), 0);
    rdQ.delete();
    sbQ.delete();
    rdCount   = 0;
    xferCount = 0;
    resetn    = 1'b1;
    tick(5);
    check("t6_idle_busy", 32'(busy), 0);
    check("t6_idle_done", 32'(done), 0);
    check("t6_idle_reads", rdCount, 0);
    check("t6_idle_xfers", xferCount, 0);
    startRun(8'h20, 8'h21);
    waitDone(40, "t6_done");
    check("t6_xfers", xferCount, 2);
    check("t6_sb_empty", sbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
